hazard_scoreboard: RTL

HAZARD_SCOREBOARD -- requirements
Module: hazard_scoreboard

---
 rtl/hazard_scoreboard.sv | 120 ++++++++++++
 1 files changed

// File: rtl/hazard_scoreboard.sv
// Pipeline hazard unit with a per-register FP write scoreboard, a divider
// occupancy counter, load-use detection and M/W operand forwarding.
module hazard_scoreboard #(
  parameter int ADDR_W  = 5,
  parameter int NREGS   = 2**ADDR_W,
  parameter int CNT_W   = 3,
  parameter int LAT_ADD = 3,
  parameter int LAT_SUB = 3,
  parameter int LAT_MUL = 4,
  parameter int LAT_DIV = 6
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] Rs1D,
  input  logic [ADDR_W-1:0] Rs2D,
  input  logic [ADDR_W-1:0] RdD,
  input  logic              IsFpD,
  input  logic [ADDR_W-1:0] Rs1E,
  input  logic [ADDR_W-1:0] Rs2E,
  input  logic [ADDR_W-1:0] RdE,
  input  logic              IsFpE,
  input  logic [1:0]        FpOpE,
  input  logic [1:0]        ResultSrcE,
  input  logic              PCSrcE,
  input  logic [ADDR_W-1:0] RdM,
  input  logic [ADDR_W-1:0] RdW,
  input  logic              RegWriteM,
  input  logic              RegWriteW,
  output logic              StallF,
  output logic              StallD,
  output logic              FlushD,
  output logic              FlushE,
  output logic [1:0]        ForwardAE,
  output logic [1:0]        ForwardBE,
  output logic              DivBusy,
  output logic [NREGS-1:0]  PendingMask
);

  logic [CNT_W-1:0] r_cnt [NREGS];
  logic [CNT_W-1:0] r_div_cnt;

  logic             w_issue;
  logic             w_div_issue;
  logic [CNT_W-1:0] w_lat_m1;
  logic [NREGS-1:0] w_pending;
  logic             w_lw_hazard;
  logic             w_raw_hazard;
  logic             w_waw_hazard;
  logic             w_struct_hazard;
  logic             w_stall;

  // A squashed (branch-taken) E op never reaches the scoreboard.
  assign w_issue     = IsFpE && (RdE != '0) && !PCSrcE;
  assign w_div_issue = w_issue && (FpOpE == 2'b11);

  always_comb begin
    w_lat_m1 = CNT_W'(LAT_ADD - 1);
    case (FpOpE)
      2'b00:   w_lat_m1 = CNT_W'(LAT_ADD - 1);
      2'b01:   w_lat_m1 = CNT_W'(LAT_SUB - 1);
      2'b10:   w_lat_m1 = CNT_W'(LAT_MUL - 1);
      default: w_lat_m1 = CNT_W'(LAT_DIV - 1);
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NREGS; i++) r_cnt[i] <= '0;
      r_div_cnt <= '0;
    end else begin
      // A new issue overrides the decrement of the same entry.
      for (int i = 0; i < NREGS; i++) begin
        if (w_issue && (RdE == ADDR_W'(i)))
          r_cnt[i] <= w_lat_m1;
        else if (r_cnt[i] != '0)
          r_cnt[i] <= r_cnt[i] - CNT_W'(1);
      end
      if (w_div_issue)
        r_div_cnt <= CNT_W'(LAT_DIV - 1);
      else if (r_div_cnt != '0)
        r_div_cnt <= r_div_cnt - CNT_W'(1);
    end
  end

  always_comb begin
    w_pending = '0;
    for (int i = 0; i < NREGS; i++) w_pending[i] = (r_cnt[i] != '0);
  end

  assign PendingMask = w_pending;
  assign DivBusy     = (r_div_cnt != '0);

  assign w_lw_hazard = (ResultSrcE == 2'b01) && (RdE != '0) &&
                       ((Rs1D == RdE) || (Rs2D == RdE));

  assign w_raw_hazard =
    ((Rs1D != '0) && (w_pending[Rs1D] || (IsFpE && (RdE == Rs1D)))) ||
    ((Rs2D != '0) && (w_pending[Rs2D] || (IsFpE && (RdE == Rs2D))));

  assign w_waw_hazard = IsFpD && (RdD != '0) &&
                        (w_pending[RdD] || (IsFpE && (RdE == RdD)));

  assign w_struct_hazard = IsFpD && (DivBusy || (IsFpE && (FpOpE == 2'b11)));

  assign w_stall = w_lw_hazard | w_raw_hazard | w_waw_hazard | w_struct_hazard;
  assign StallF  = w_stall;
  assign StallD  = w_stall;
  assign FlushD  = PCSrcE;
  assign FlushE  = w_stall | PCSrcE;

  function automatic logic [1:0] fwd_sel(input logic [ADDR_W-1:0] rs);
    if ((rs != '0) && RegWriteM && (rs == RdM))      return 2'b10;
    else if ((rs != '0) && RegWriteW && (rs == RdW)) return 2'b01;
    else                                              return 2'b00;
  endfunction

  assign ForwardAE = fwd_sel(Rs1E);
  assign ForwardBE = fwd_sel(Rs2E);

endmodule
